// File: rtl/alu_writeback.sv
// Writeback sequencer: buffers dual-result ALU bundles and drains them
// onto the single register-file write port, one write per cycle.
module alu_writeback #(
  parameter int DEPTH    = 2,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_Y1,
  input  logic [31:0]         in_Y2,
  input  logic [REG_BITS-1:0] in_rd1,
  input  logic [REG_BITS-1:0] in_rd2,
  input  logic [1:0]          in_we,
  input  logic                wb_stall,
  output logic                rf_we,
  output logic [REG_BITS-1:0] rf_waddr,
  output logic [31:0]         rf_wdata,
  output logic                busy
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0]         y1;
    logic [31:0]         y2;
    logic [REG_BITS-1:0] rd1;
    logic [REG_BITS-1:0] rd2;
    logic [1:0]          we;
  } entry_t;

  entry_t              mem_q [DEPTH];
  logic [PW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]         cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic                rf_we_q, rf_we_d;
  logic [REG_BITS-1:0] rf_waddr_q, rf_waddr_d;
  logic [31:0]         rf_wdata_q, rf_wdata_d;

  entry_t head;
  logic   push, issue, sel_y2, last, pop;

  assign in_ready = !rst && (cnt_q < FULL);
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = (cnt_q != '0) || rf_we_q;

  always_comb begin
    head   = mem_q[rptr_q];
    // Fully masked bundles finish the handshake but never occupy a slot.
    push   = in_valid && in_ready && (in_we != 2'b00);
    issue  = (cnt_q != '0) && !wb_stall;
    sel_y2 = phase_q || !head.we[0];
    last   = phase_q || (head.we != 2'b11);
    pop    = issue && last;

    wptr_d     = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d     = pop  ? rptr_q + PW'(1) : rptr_q;
    cnt_d      = cnt_q;
    if (push && !pop) cnt_d = cnt_q + (PW+1)'(1);
    if (pop && !push) cnt_d = cnt_q - (PW+1)'(1);
    phase_d    = phase_q;
    rf_we_d    = issue;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (issue) begin
      rf_waddr_d = sel_y2 ? head.rd2 : head.rd1;
      rf_wdata_d = sel_y2 ? head.y2  : head.y1;
      phase_d    = !last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= '{y1: in_Y1, y2: in_Y2, rd1: in_rd1, rd2: in_rd2, we: in_we};
  end
endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed scenarios plus random traffic, all
// checked against a queue-of-pending-writes reference model.
module tb_alu_writeback;
  localparam int DEPTH = 2;
  localparam int RB    = 5;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, wb_stall, rf_we, busy;
  logic [31:0]   in_Y1, in_Y2, rf_wdata;
  logic [RB-1:0] in_rd1, in_rd2, rf_waddr;
  logic [1:0]    in_we;

  alu_writeback #(.DEPTH(DEPTH), .REG_BITS(RB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_Y1(in_Y1), .in_Y2(in_Y2), .in_rd1(in_rd1), .in_rd2(in_rd2),
    .in_we(in_we), .wb_stall(wb_stall), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: flat list of register writes still owed, in program order.
  // 'last' marks the final write of a bundle, so bundles held = count of 'last'.
  typedef struct {
    logic [RB-1:0] a;
    logic [31:0]   d;
    bit            last;
  } wr_t;
  wr_t           q[$];
  logic          e_we;
  logic [RB-1:0] e_addr;
  logic [31:0]   e_data;
  logic          e_rdy;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int bundles();
    int n = 0;
    foreach (q[i]) if (q[i].last) n++;
    return n;
  endfunction

  // One clock cycle: check registered outputs, drive inputs, check in_ready,
  // then advance the model to what the next edge should produce.
  task automatic cyc(input logic r, input logic v, input logic [31:0] y1, input logic [31:0] y2,
                     input logic [RB-1:0] d1, input logic [RB-1:0] d2, input logic [1:0] we,
                     input logic st);
    wr_t w;
    @(negedge clk);
    chk("rf_we", rf_we, e_we);
    if (e_we) begin
      chk("rf_waddr", rf_waddr, e_addr);
      chk("rf_wdata", rf_wdata, e_data);
    end
    chk("busy", busy, (bundles() != 0) || e_we);
    rst = r; in_valid = v; in_Y1 = y1; in_Y2 = y2;
    in_rd1 = d1; in_rd2 = d2; in_we = we; wb_stall = st;
    #1;
    e_rdy = !r && (bundles() < DEPTH);
    chk("in_ready", in_ready, e_rdy);
    if (r) begin
      q.delete();
      e_we = 0; e_addr = '0; e_data = '0;
    end else begin
      if (q.size() != 0 && !st) begin
        w = q.pop_front();
        e_we = 1; e_addr = w.a; e_data = w.d;
      end else e_we = 0;
      if (v && e_rdy) begin
        if (we[0]) q.push_back('{a: d1, d: y1, last: !we[1]});
        if (we[1]) q.push_back('{a: d2, d: y2, last: 1'b1});
      end
    end
  endtask

  task automatic idle(input int n, input logic st);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, '0, '0, '0, 2'b00, st);
  endtask

  logic [31:0] by1[3];
  logic [4:0]  brd[3];

  initial begin
    rst = 1; in_valid = 0; in_Y1 = '0; in_Y2 = '0; in_rd1 = '0; in_rd2 = '0;
    in_we = '0; wb_stall = 0;
    e_we = 0; e_addr = '0; e_data = '0; e_rdy = 0;
    repeat (2) @(posedge clk);

    // Reset state, then a single Y1 write.
    cyc(1, 0, '0, '0, '0, '0, 2'b00, 0);
    cyc(0, 1, 32'h11111111, 32'h0, 5'd3, 5'd0, 2'b01, 0);
    idle(3, 0);

    // Dual write to the same register: Y2 must land last.
    cyc(0, 1, 32'hAAAA0000, 32'h0000BBBB, 5'd7, 5'd7, 2'b11, 0);
    idle(4, 0);

    // Backpressure: hold each bundle until the model says it was accepted.
    by1 = '{32'hB0000001, 32'hB0000002, 32'hB0000003};
    brd = '{5'd1, 5'd2, 5'd4};
    begin
      int k = 0;
      for (int c = 0; c < 20 && k < 3; c++) begin
        cyc(0, 1, by1[k], 32'h0, brd[k], 5'd0, 2'b01, c < 5);
        if (e_rdy) k++;
      end
      chk("bp_all_accepted", k, 3);
    end
    idle(5, 0);

    // Stall between Y1 and Y2 of one bundle.
    cyc(0, 1, 32'hC1C1C1C1, 32'hC2C2C2C2, 5'd10, 5'd11, 2'b11, 0);
    idle(1, 0);
    idle(3, 1);
    idle(3, 0);

    // Fully masked bundle followed by a Y2-only bundle.
    cyc(0, 1, 32'hDEAD0000, 32'hDEAD0001, 5'd12, 5'd13, 2'b00, 0);
    cyc(0, 1, 32'hDEAD0002, 32'd5, 5'd14, 5'd9, 2'b10, 0);
    idle(3, 0);

    // Reset while Y2 is still pending; nothing stale may follow.
    cyc(0, 1, 32'hE1E1E1E1, 32'hE2E2E2E2, 5'd20, 5'd21, 2'b11, 0);
    cyc(0, 0, '0, '0, '0, '0, 2'b00, 0);
    cyc(1, 1, 32'hF0F0F0F0, 32'h0, 5'd22, 5'd0, 2'b01, 0);
    idle(4, 0);

    // Random traffic with stalls and rare resets.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(99) == 0), ($urandom_range(9) < 6), $urandom, $urandom,
          RB'($urandom_range(31)), RB'($urandom_range(31)), 2'($urandom_range(3)),
          ($urandom_range(9) < 3));
    end
    idle(8, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
